// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared lamp constants, player state encoding and one-hot lamp helper
package memory_game_pkg;

   localparam int NUM_LAMPS     = 5;
   localparam int IDX_W         = 3;
   localparam int LEN_W         = 6;
   localparam int DEF_ON_TICKS  = 2;
   localparam int DEF_GAP_TICKS = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_ON    = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } player_state_t;

   // Out-of-range indices map to all-dark so a corrupt entry never lights a lamp.
   function automatic logic [NUM_LAMPS-1:0] lamp_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_LAMPS-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_LAMPS; i++) begin
         if (idx == IDX_W'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - counts tick strobes after a load and pulses expire on the i_count-th one
module tick_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             i_load,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   // A tick coinciding with the load belongs to the previous window and is dropped.
   assign w_last   = (r_cnt == i_count - 1'b1);
   assign o_expire = i_tick & ~i_load & w_last;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cnt <= '0;
      end else if (i_load || o_expire) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - plays the stored lamp sequence from the sequence RAM, one step per tick window
module sequence_player
   import memory_game_pkg::*;
#(
   parameter int ON_TICKS  = DEF_ON_TICKS,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 i_tick,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [LEN_W-1:0]     i_len,
   output logic [LEN_W-1:0]     o_rd_addr,
   input  logic [IDX_W-1:0]     i_rd_data,
   output logic [NUM_LAMPS-1:0] o_lamps,
   output logic                 o_step_strobe,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   localparam int TMAX   = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int TCNT_W = $clog2(TMAX + 1);
   localparam logic [TCNT_W-1:0] ON_CNT  = TCNT_W'(ON_TICKS);
   localparam logic [TCNT_W-1:0] GAP_CNT = TCNT_W'(GAP_TICKS);

   player_state_t        r_state;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_ptr;
   logic [LEN_W-1:0]     r_rd_addr;
   logic [NUM_LAMPS-1:0] r_lamps;
   logic                 r_step_strobe;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic                 r_entry;

   logic                 w_timed;
   logic                 w_tick;
   logic [TCNT_W-1:0]    w_tcount;
   logic                 w_expire;
   logic [NUM_LAMPS-1:0] w_lamp_oh;

   assign w_timed   = (r_state == ST_ON) || (r_state == ST_GAP);
   assign w_tick    = i_tick & w_timed;
   assign w_tcount  = (r_state == ST_GAP) ? GAP_CNT : ON_CNT;
   assign w_lamp_oh = lamp_onehot(i_rd_data);

   // One timer serves both windows; r_entry marks the first cycle of ON or GAP.
   tick_timer #(
      .CNT_W(TCNT_W)
   ) u_tick_timer (
      .clk      (clk),
      .resetN   (resetN),
      .i_load   (r_entry),
      .i_tick   (w_tick),
      .i_count  (w_tcount),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state       <= ST_IDLE;
         r_len         <= '0;
         r_ptr         <= '0;
         r_rd_addr     <= '0;
         r_lamps       <= '0;
         r_step_strobe <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_entry       <= 1'b0;
      end else begin
         r_step_strobe <= 1'b0;
         r_done        <= 1'b0;
         r_entry       <= 1'b0;
         if (i_abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_lamps <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start && !i_abort) begin
                     r_len <= i_len;
                     r_ptr <= '0;
                     r_err <= 1'b0;
                     if (i_len == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= ST_FETCH;
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                     end
                  end
               end
               ST_FETCH: r_state <= ST_LATCH;
               ST_LATCH: begin
                  r_lamps       <= w_lamp_oh;
                  r_err         <= r_err | (w_lamp_oh == '0);
                  r_step_strobe <= 1'b1;
                  r_entry       <= 1'b1;
                  r_state       <= ST_ON;
               end
               ST_ON: begin
                  if (w_expire) begin
                     r_lamps <= '0;
                     r_entry <= 1'b1;
                     r_state <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  if (w_expire) begin
                     if (r_ptr == r_len - 1'b1) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_ptr     <= r_ptr + 1'b1;
                        r_rd_addr <= r_ptr + 1'b1;
                        r_state   <= ST_FETCH;
                     end
                  end
               end
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_rd_addr     = r_rd_addr;
   assign o_lamps       = r_lamps;
   assign o_step_strobe = r_step_strobe;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_err         = r_err;

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - scoreboard bench for sequence_player with a registered-read RAM model
module tb_sequence_player;

   logic       clk;
   logic       resetN;
   logic       i_tick;
   logic       i_start;
   logic       i_abort;
   logic [5:0] i_len;
   logic [5:0] o_rd_addr;
   logic [2:0] i_rd_data;
   logic [4:0] o_lamps;
   logic       o_step_strobe;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   logic [2:0] ram [0:63];
   logic [4:0] exp_q [$];
   int         on_q [$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         n_strobe = 0;
   int         n_done   = 0;
   int         lit_cnt  = 0;

   sequence_player dut (
      .clk           (clk),
      .resetN        (resetN),
      .i_tick        (i_tick),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_len         (i_len),
      .o_rd_addr     (o_rd_addr),
      .i_rd_data     (i_rd_data),
      .o_lamps       (o_lamps),
      .o_step_strobe (o_step_strobe),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) i_rd_data <= ram[o_rd_addr];

   initial begin
      i_tick = 1'b0;
      forever begin
         repeat (9) @(posedge clk);
         #1 i_tick = 1'b1;
         @(posedge clk);
         #1 i_tick = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_step_strobe) begin
         n_strobe++;
         check("exp_q_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("step_lamps", o_lamps, exp_q.pop_front());
      end
      if (o_done) begin
         n_done++;
         check("busy_at_done", o_busy, 0);
         check("lamps_at_done", o_lamps, 0);
      end
      if (o_lamps != 0) lit_cnt++;
      else if (lit_cnt != 0) begin
         on_q.push_back(lit_cnt);
         lit_cnt = 0;
      end
   end

   task automatic start_seq(input logic [5:0] len);
      @(posedge clk);
      #1 i_len = len;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      on_q.delete();
      n_strobe = 0;
      n_done   = 0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && n_done == 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("done_seen", n_done, 1);
   endtask

   task automatic wait_strobes(input int target, input int budget);
      for (int i = 0; i < budget && n_strobe < target; i++) begin
         @(negedge clk);
         #1;
      end
      check("strobe_reached", n_strobe >= target, 1);
   endtask

   task automatic check_windows(input int count);
      check("window_count", on_q.size(), count);
      foreach (on_q[k]) check("on_window_len", (on_q[k] >= 11) && (on_q[k] <= 21), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN  = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_len   = '0;
      for (int i = 0; i < 64; i++) ram[i] = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_lamps", o_lamps, 0);
      check("rst_ctrl", {o_busy, o_done, o_step_strobe, o_err}, 0);
      check("rst_rd_addr", o_rd_addr, 0);
      @(posedge clk);
      #3 resetN = 1'b1;

      // Basic three-step playback with latency and window timing
      ram[0] = 3'd2; ram[1] = 3'd0; ram[2] = 3'd4;
      clear_sb();
      exp_q.push_back(5'b00100); exp_q.push_back(5'b00001); exp_q.push_back(5'b10000);
      start_seq(6'd3);
      check("busy_after_start", o_busy, 1);
      @(posedge clk); #1;
      check("dark_in_latch", o_lamps, 0);
      check("rd_addr_step0", o_rd_addr, 0);
      @(posedge clk); #1;
      check("first_lamp_latency", o_lamps, 5'b00100);
      check("first_strobe", o_step_strobe, 1);
      wait_done(400);
      @(posedge clk); #1;
      check("busy_after_done", o_busy, 0);
      check("done_one_clk", o_done, 0);
      check("strobes_3", n_strobe, 3);
      check("exp_q_drained", exp_q.size(), 0);
      check_windows(3);

      // Repeated lamp must be separated by a dark gap
      ram[0] = 3'd3; ram[1] = 3'd3;
      clear_sb();
      exp_q.push_back(5'b01000); exp_q.push_back(5'b01000);
      start_seq(6'd2);
      wait_done(400);
      check("strobes_2", n_strobe, 2);
      check_windows(2);

      // Empty sequence
      clear_sb();
      start_seq(6'd0);
      @(negedge clk);
      check("len0_done", o_done, 1);
      check("len0_lamps", o_lamps, 0);
      check("len0_busy", o_busy, 0);
      repeat (3) @(negedge clk);
      check("len0_rd_addr", o_rd_addr, 1);
      check("len0_strobes", n_strobe, 0);

      // Out-of-range index plays dark and sets err
      ram[0] = 3'd1; ram[1] = 3'd7;
      clear_sb();
      exp_q.push_back(5'b00010); exp_q.push_back(5'b00000);
      start_seq(6'd2);
      wait_done(400);
      check("err_set", o_err, 1);
      check_windows(1);

      // Abort mid-ON of step 1, with an ignored second start
      ram[0] = 3'd0; ram[1] = 3'd1; ram[2] = 3'd2; ram[3] = 3'd3;
      clear_sb();
      exp_q.push_back(5'b00001); exp_q.push_back(5'b00010);
      exp_q.push_back(5'b00100); exp_q.push_back(5'b01000);
      start_seq(6'd4);
      check("err_cleared_by_start", o_err, 0);
      wait_strobes(1, 100);
      start_seq(6'd1);
      check("busy_start_ignored", o_busy, 1);
      check("lamps_start_ignored", o_lamps, 5'b00001);
      wait_strobes(2, 200);
      @(posedge clk);
      #1 i_abort = 1'b1;
      @(posedge clk);
      #1 i_abort = 1'b0;
      check("abort_lamps", o_lamps, 0);
      check("abort_busy", o_busy, 0);
      repeat (60) @(negedge clk);
      check("no_done_after_abort", n_done, 0);
      check("strobes_at_abort", n_strobe, 2);

      // Abort together with start in IDLE drops the start
      exp_q.delete();
      @(posedge clk);
      #1 i_start = 1'b1; i_abort = 1'b1; i_len = 6'd3;
      @(posedge clk);
      #1 i_start = 1'b0; i_abort = 1'b0;
      check("abort_start_busy", o_busy, 0);
      repeat (5) @(negedge clk);
      check("abort_start_strobes", n_strobe, 2);

      // Asynchronous reset mid-sequence, then replay from step 0
      ram[0] = 3'd2; ram[1] = 3'd0; ram[2] = 3'd4;
      clear_sb();
      exp_q.push_back(5'b00100); exp_q.push_back(5'b00001); exp_q.push_back(5'b10000);
      start_seq(6'd3);
      wait_strobes(2, 200);
      @(posedge clk);
      #3 resetN = 1'b0;
      #1;
      check("async_rst_lamps", o_lamps, 0);
      check("async_rst_outs", {o_busy, o_done, o_step_strobe, o_err, o_rd_addr}, 0);
      repeat (2) @(posedge clk);
      #3 resetN = 1'b1;
      clear_sb();
      exp_q.push_back(5'b00100); exp_q.push_back(5'b00001); exp_q.push_back(5'b10000);
      start_seq(6'd3);
      wait_done(400);
      check("replay_strobes", n_strobe, 3);
      check("replay_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
